// File: rtl/biriscv_mul_wb_tracker_pkg.sv
// Shared types and constants for the multiplier writeback sideband tracker.
// The stage entry carries everything a completing multiply needs besides its data.
package biriscv_mul_wb_tracker_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] pc;
    } mul_stage_t;

    localparam int MULT_STAGES_MIN = 2;
    localparam int MULT_STAGES_MAX = 3;

    localparam logic [4:0] RD_ZERO = 5'd0;

    function automatic logic mult_stages_legal(input int n);
        return (n >= MULT_STAGES_MIN) && (n <= MULT_STAGES_MAX);
    endfunction

endpackage

// File: rtl/biriscv_mul_track_stage.sv
// One sideband pipeline stage that moves in lock-step with a multiplier stage.
// Flush clears only the valid bit, even when the pipeline is held.
module biriscv_mul_track_stage
    import biriscv_mul_wb_tracker_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic       flush_i,
    input  mul_stage_t entry_i,
    output mul_stage_t entry_o
);

    mul_stage_t entry_q;
    mul_stage_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (!hold_i) begin
            entry_d = entry_i;
        end
        if (flush_i) begin
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/biriscv_mul_wb_tracker.sv
// Tracks rd/pc of in-flight multiplies, pairs the final stage with the multiplier
// result for writeback, and publishes a pending-rd mask for RAW hazard stalls.
module biriscv_mul_wb_tracker
    import biriscv_mul_wb_tracker_pkg::*;
#(
    parameter int MULT_STAGES = 2
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [31:0] issue_pc_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] mul_result_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] busy_mask_o,
    output logic [1:0]  inflight_o,
    output logic [31:0] mul_retired_o
);

    mul_stage_t stage_in  [MULT_STAGES];
    mul_stage_t stage_out [MULT_STAGES];
    mul_stage_t final_e;

    logic [31:0] retired_q;
    logic [31:0] retired_d;
    logic        wb_valid;
    logic [31:0] busy_mask;
    logic [1:0]  inflight;

    for (genvar g = 0; g < MULT_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            // A flushing cycle drops its own issue.
            assign stage_in[g] = '{valid: issue_valid_i & ~flush_i,
                                   rd:    issue_rd_idx_i,
                                   pc:    issue_pc_i};
        end else begin : g_chain
            assign stage_in[g] = stage_out[g-1];
        end

        biriscv_mul_track_stage u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .hold_i  (hold_i),
            .flush_i (flush_i),
            .entry_i (stage_in[g]),
            .entry_o (stage_out[g])
        );
    end

    assign final_e = stage_out[MULT_STAGES-1];

    always_comb begin
        busy_mask = '0;
        inflight  = '0;
        for (int i = 0; i < MULT_STAGES; i++) begin
            if (stage_out[i].valid) begin
                inflight = inflight + 2'd1;
                busy_mask[stage_out[i].rd] = 1'b1;
            end
        end
        // x0 is never a real hazard.
        busy_mask[0] = 1'b0;
    end

    // The final entry retires even in a flush cycle: it is older than the flusher.
    assign wb_valid = final_e.valid & ~hold_i & (final_e.rd != RD_ZERO);

    always_comb begin
        retired_d = retired_q;
        if (wb_valid) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign wb_valid_o    = wb_valid;
    assign wb_rd_idx_o   = final_e.valid ? final_e.rd : 5'd0;
    assign wb_pc_o       = final_e.valid ? final_e.pc : 32'd0;
    assign wb_value_o    = wb_valid ? mul_result_i : 32'd0;
    assign busy_mask_o   = busy_mask;
    assign inflight_o    = inflight;
    assign mul_retired_o = retired_q;

endmodule

// File: tb/tb_biriscv_mul_wb_tracker.sv
// Bench for the multiplier writeback tracker: a list-of-ops reference model feeds
// an expected-writeback queue that a negedge monitor drains and compares.
module tb_biriscv_mul_wb_tracker;

    localparam int S = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_idx_i;
    logic [31:0] issue_pc_i;
    logic        hold_i;
    logic        flush_i;
    logic [31:0] mul_result_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_value_o;
    logic [31:0] wb_pc_o;
    logic [31:0] busy_mask_o;
    logic [1:0]  inflight_o;
    logic [31:0] mul_retired_o;

    biriscv_mul_wb_tracker #(.MULT_STAGES(S)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_idx_i (issue_rd_idx_i),
        .issue_pc_i     (issue_pc_i),
        .hold_i         (hold_i),
        .flush_i        (flush_i),
        .mul_result_i   (mul_result_i),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_idx_o    (wb_rd_idx_o),
        .wb_value_o     (wb_value_o),
        .wb_pc_o        (wb_pc_o),
        .busy_mask_o    (busy_mask_o),
        .inflight_o     (inflight_o),
        .mul_retired_o  (mul_retired_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each in-flight op is a record with the number of advancing edges it has seen;
    // an op whose age equals S is the one completing this cycle. Oldest at front.
    logic [4:0]  m_rd  [$];
    logic [31:0] m_pc  [$];
    int          m_age [$];
    logic [31:0] model_cnt = '0;

    // {rd, pc, value}
    logic [68:0] exp_q [$];

    logic        exp_wb_valid;
    logic [4:0]  exp_wb_rd;
    logic [31:0] exp_wb_pc;
    logic [31:0] exp_busy;
    logic [1:0]  exp_inflight;
    logic [31:0] exp_cnt;
    logic        mon_en = 1'b0;

    task automatic model_clear();
        m_rd.delete();
        m_pc.delete();
        m_age.delete();
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic iv, input logic [4:0] rd, input logic [31:0] pc,
                         input logic hd, input logic fl, input logic [31:0] res);
        logic fin;
        issue_valid_i  = iv;
        issue_rd_idx_i = rd;
        issue_pc_i     = pc;
        hold_i         = hd;
        flush_i        = fl;
        mul_result_i   = res;

        fin          = 1'b0;
        exp_wb_rd    = '0;
        exp_wb_pc    = '0;
        exp_busy     = '0;
        for (int i = 0; i < m_age.size(); i++) begin
            if (m_rd[i] != 5'd0) exp_busy = exp_busy | (32'd1 << m_rd[i]);
            if (m_age[i] == S) begin
                fin       = 1'b1;
                exp_wb_rd = m_rd[i];
                exp_wb_pc = m_pc[i];
            end
        end
        exp_inflight = 2'(m_age.size());
        exp_wb_valid = fin && !hd && (exp_wb_rd != 5'd0);
        exp_cnt      = model_cnt;
        if (exp_wb_valid) exp_q.push_back({exp_wb_rd, exp_wb_pc, res});
        mon_en = 1'b1;

        @(posedge clk_i);
        if (exp_wb_valid) model_cnt = model_cnt + 32'd1;
        if (fl) begin
            model_clear();
        end else if (!hd) begin
            for (int i = 0; i < m_age.size(); i++) m_age[i] = m_age[i] + 1;
            if (m_age.size() > 0 && m_age[0] > S) begin
                void'(m_rd.pop_front());
                void'(m_pc.pop_front());
                void'(m_age.pop_front());
            end
            if (iv) begin
                m_rd.push_back(rd);
                m_pc.push_back(pc);
                m_age.push_back(1);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, $urandom());
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        if (mon_en) begin
            logic [68:0] e;
            chk("wb_valid", {31'd0, wb_valid_o}, {31'd0, exp_wb_valid});
            chk("wb_rd_idx", {27'd0, wb_rd_idx_o}, {27'd0, exp_wb_rd});
            chk("wb_pc", wb_pc_o, exp_wb_pc);
            chk("busy_mask", busy_mask_o, exp_busy);
            chk("inflight", {30'd0, inflight_o}, {30'd0, exp_inflight});
            chk("mul_retired", mul_retired_o, exp_cnt);
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_q_rd", {27'd0, wb_rd_idx_o}, {27'd0, e[68:64]});
                    chk("wb_q_pc", wb_pc_o, e[63:32]);
                    chk("wb_q_value", wb_value_o, e[31:0]);
                end
            end else begin
                chk("wb_value_idle", wb_value_o, 32'd0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, wb_rd_idx_o}, 32'd0);
        chk({tag, "_wb_value"}, wb_value_o, 32'd0);
        chk({tag, "_wb_pc"}, wb_pc_o, 32'd0);
        chk({tag, "_busy"}, busy_mask_o, 32'd0);
        chk({tag, "_inflight"}, {30'd0, inflight_o}, 32'd0);
        chk({tag, "_retired"}, mul_retired_o, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i          = 1'b1;
        issue_valid_i  = 1'b0;
        issue_rd_idx_i = '0;
        issue_pc_i     = '0;
        hold_i         = 1'b0;
        flush_i        = 1'b0;
        mul_result_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // single op, fixed result
        cycle(1'b1, 5'd5, 32'h8000_0010, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0000_002A);
        chk("retired_after_first", mul_retired_o, 32'd1);

        // back-to-back issue
        cycle(1'b1, 5'd1, 32'h0000_1000, 1'b0, 1'b0, $urandom());
        cycle(1'b1, 5'd2, 32'h0000_1004, 1'b0, 1'b0, $urandom());
        chk("b2b_busy_peak_a", busy_mask_o, 32'h0000_0006);
        cycle(1'b1, 5'd3, 32'h0000_1008, 1'b0, 1'b0, $urandom());
        chk("b2b_busy_peak_b", busy_mask_o, 32'h0000_000C);
        idle(3);

        // hold while the op sits in the final stage
        cycle(1'b1, 5'd7, 32'h0000_2000, 1'b0, 1'b0, $urandom());
        idle(1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, $urandom());
        idle(2);

        // flush catches the op in e1
        cycle(1'b1, 5'd4, 32'h0000_3000, 1'b0, 1'b0, $urandom());
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, $urandom());
        chk("flush_inflight", {30'd0, inflight_o}, 32'd0);
        idle(3);

        // rd=0 op occupies a slot but never writes back
        cycle(1'b1, 5'd0, 32'h0000_4000, 1'b0, 1'b0, $urandom());
        chk("rd0_inflight", {30'd0, inflight_o}, 32'd1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0), $urandom());
        end
        idle(4);

        // counter wrap: park the counter at all-ones for one idle edge
        force dut.retired_q = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        idle(1);
        release dut.retired_q;
        cycle(1'b1, 5'd9, 32'h0000_5000, 1'b0, 1'b0, $urandom());
        idle(2);
        chk("retired_wrap", mul_retired_o, 32'd0);

        // reset with two ops in flight
        cycle(1'b1, 5'd10, 32'h0000_6000, 1'b0, 1'b0, $urandom());
        cycle(1'b1, 5'd11, 32'h0000_6004, 1'b0, 1'b0, $urandom());
        chk("pre_reset_inflight", {30'd0, inflight_o}, 32'd2);
        mon_en        = 1'b0;
        issue_valid_i = 1'b0;
        rst_i         = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
        model_cnt = '0;
        @(posedge clk_i);
        #1;
        idle(4);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
